icache: RTL and testbench

Direct-mapped instruction cache between the instruction fetcher and `memory_controller`. Serves 32-bit instruction fetches on a hit in one cycle. On a miss, it sequences a multi-word line refill through the controller's instruction port (`ic_flag`/`ins_addr`/`ins`/`ins_rdy`), then answers the pending fetch. Branch-misprediction flush cancels the pending answer without breaking the memory handshake.

---
 rtl/cpu_defs.sv | 13 +
 rtl/icache_array.sv | 60 ++++++
 rtl/icache.sv | 157 +++++++++++++++
 tb/tb_icache.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU-wide widths and the instruction-cache state encoding.
package cpu_defs;

    localparam int ADDR_W = 32;
    localparam int INS_W  = 32;

    typedef enum logic [1:0] {
        IC_IDLE,
        IC_REFILL,
        IC_RESP
    } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// One combinational read port and one write port for the refill word and line tag.
module icache_array
    import cpu_defs::*;
#(
    parameter int IDX_BITS = 4,
    parameter int OFS_BITS = 2,
    parameter int TAG_BITS = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    input  logic [OFS_BITS-1:0] rd_ofs,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [INS_W-1:0]    rd_word,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [OFS_BITS-1:0] wr_ofs,
    input  logic [INS_W-1:0]    wr_word,
    input  logic                tag_we,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic                inv_en
);

    localparam int LINES = 1 << IDX_BITS;
    localparam int WORDS = 1 << OFS_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [INS_W-1:0]    data_q [LINES*WORDS];

    // Only the valid bits need a reset; tags and data are qualified by them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[wr_idx] <= 1'b1;
        end else if (inv_en) begin
            valid_q[wr_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{wr_idx, wr_ofs}] <= wr_word;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[{rd_idx, rd_ofs}];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: single-cycle hits, in-order line refill
// through the memory controller's instruction port, flush-cancellable response.
module icache
    import cpu_defs::*;
#(
    parameter int IDX_BITS = 4,
    parameter int OFS_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_busy,
    output logic [INS_W-1:0]  ins_out,
    output logic              ins_out_valid,
    output logic              ic_flag,
    output logic [ADDR_W-1:0] ins_addr,
    input  logic [INS_W-1:0]  ins,
    input  logic              ins_rdy
);

    localparam int TAG_BITS = ADDR_W - IDX_BITS - OFS_BITS - 2;

    function automatic logic [IDX_BITS-1:0] pc_index(input logic [ADDR_W-1:0] pc);
        return pc[IDX_BITS+OFS_BITS+1:OFS_BITS+2];
    endfunction

    function automatic logic [TAG_BITS-1:0] pc_tag(input logic [ADDR_W-1:0] pc);
        return pc[ADDR_W-1:IDX_BITS+OFS_BITS+2];
    endfunction

    function automatic logic [OFS_BITS-1:0] pc_offset(input logic [ADDR_W-1:0] pc);
        return pc[OFS_BITS+1:2];
    endfunction

    ic_state_e           state, state_next;
    logic [OFS_BITS-1:0] cnt;
    logic [ADDR_W-1:0]   pc_q;
    logic                cancel;
    logic                hit_valid_q;
    logic [INS_W-1:0]    hit_data_q;

    logic [IDX_BITS-1:0] line_idx;
    logic [OFS_BITS-1:0] line_ofs;
    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [INS_W-1:0]    rd_word;
    logic                hit;
    logic                last_word;
    logic                wr_en;
    logic                tag_we;
    logic                inv_en;
    logic [3:0]          unused_pc_bits;

    assign unused_pc_bits = {fetch_pc[1:0], pc_q[1:0]};

    // In IDLE the array is looked up with the incoming pc, otherwise with the latched miss pc.
    assign line_idx  = (state == IC_IDLE) ? pc_index(fetch_pc)  : pc_index(pc_q);
    assign line_ofs  = (state == IC_IDLE) ? pc_offset(fetch_pc) : pc_offset(pc_q);
    assign hit       = rd_valid && (rd_tag == pc_tag(fetch_pc));
    assign last_word = (cnt == {OFS_BITS{1'b1}});
    assign wr_en     = rdy && (state == IC_REFILL) && ins_rdy;
    assign tag_we    = wr_en && last_word;
    assign inv_en    = rdy && (state == IC_IDLE) && fetch_valid && !hit;

    icache_array #(
        .IDX_BITS (IDX_BITS),
        .OFS_BITS (OFS_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (line_idx),
        .rd_ofs   (line_ofs),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_word  (rd_word),
        .wr_en    (wr_en),
        .wr_idx   (line_idx),
        .wr_ofs   (cnt),
        .wr_word  (ins),
        .tag_we   (tag_we),
        .wr_tag   (pc_tag(pc_q)),
        .inv_en   (inv_en)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IC_IDLE;
        end else if (rdy) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IC_IDLE:   if (fetch_valid && !hit)  state_next = IC_REFILL;
            IC_REFILL: if (ins_rdy && last_word) state_next = IC_RESP;
            IC_RESP:                             state_next = IC_IDLE;
            default:                             state_next = IC_IDLE;
        endcase
    end

    // The hit response is registered; the miss response is read straight from the freshly filled line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            pc_q        <= '0;
            cancel      <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_data_q  <= '0;
        end else if (rdy) begin
            hit_valid_q <= 1'b0;
            case (state)
                IC_IDLE: begin
                    cancel <= 1'b0;
                    if (fetch_valid && hit) begin
                        hit_valid_q <= !flush;
                        hit_data_q  <= rd_word;
                    end else if (fetch_valid) begin
                        pc_q <= fetch_pc;
                        cnt  <= '0;
                    end
                end
                IC_REFILL: begin
                    if (ins_rdy) cnt    <= cnt + 1'b1;
                    if (flush)   cancel <= 1'b1;
                end
                IC_RESP: cancel <= 1'b0;
                default: cancel <= 1'b0;
            endcase
        end
    end

    always_comb begin
        ic_flag       = 1'b0;
        ins_addr      = '0;
        fetch_busy    = (state != IC_IDLE);
        ins_out       = hit_data_q;
        ins_out_valid = hit_valid_q;
        case (state)
            IC_REFILL: begin
                ic_flag  = 1'b1;
                ins_addr = {pc_tag(pc_q), pc_index(pc_q), cnt, 2'b00};
            end
            IC_RESP: begin
                ins_out       = rd_word;
                ins_out_valid = !cancel && !flush;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache; the bench itself plays the memory controller,
// returning 0xC0DE_0000 | addr[15:0] for every refill address.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_busy;
    logic [31:0] ins_out;
    logic        ins_out_valid;
    logic        ic_flag;
    logic [31:0] ins_addr;
    logic [31:0] ins = '0;
    logic        ins_rdy = 1'b0;

    int n_compared = 0;
    int n_mismatched = 0;

    icache dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .flush         (flush),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_busy    (fetch_busy),
        .ins_out       (ins_out),
        .ins_out_valid (ins_out_valid),
        .ic_flag       (ic_flag),
        .ins_addr      (ins_addr),
        .ins           (ins),
        .ins_rdy       (ins_rdy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Controller side: optionally idle, then return the word at the requested address.
    task automatic serve_word(input int gap, output logic [31:0] addr_seen);
        repeat (gap) tick();
        addr_seen = ins_addr;
        ins       = 32'hC0DE_0000 | {16'h0, ins_addr[15:0]};
        ins_rdy   = 1'b1;
        tick();
        ins_rdy   = 1'b0;
        ins       = '0;
    endtask

    task automatic issue_fetch(input logic [31:0] pc);
        fetch_pc    = pc;
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        n_compared++; if (ic_flag !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ic_flag got=%0h want=0", ic_flag); end
        n_compared++; if (fetch_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy got=%0h want=0", fetch_busy); end
        n_compared++; if (ins_out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid got=%0h want=0", ins_out_valid); end
        n_compared++; if (ins_out !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_ins_out got=%0h want=0", ins_out); end
        n_compared++; if (ins_addr !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_ins_addr got=%0h want=0", ins_addr); end
    endtask

    task automatic test_cold_miss();
        logic [31:0] a;
        issue_fetch(32'h0000_0104);
        n_compared++; if (ic_flag !== 1'b1) begin n_mismatched++; $display("[TB] FAIL cold_ic_flag got=%0h want=1", ic_flag); end
        n_compared++; if (fetch_busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL cold_busy got=%0h want=1", fetch_busy); end
        for (int k = 0; k < 4; k++) begin
            serve_word((k == 2) ? 2 : 0, a);
            n_compared++; if (a !== 32'h100 + 32'(k * 4)) begin n_mismatched++; $display("[TB] FAIL cold_addr%0d got=%0h want=%0h", k, a, 32'h100 + 32'(k * 4)); end
        end
        n_compared++; if (ins_out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL cold_resp_valid got=%0h want=1", ins_out_valid); end
        n_compared++; if (ins_out !== 32'hC0DE_0104) begin n_mismatched++; $display("[TB] FAIL cold_resp_data got=%0h want=c0de0104", ins_out); end
        n_compared++; if (ic_flag !== 1'b0) begin n_mismatched++; $display("[TB] FAIL cold_flag_drop got=%0h want=0", ic_flag); end
        tick();
        n_compared++; if (ins_out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL cold_pulse_end got=%0h want=0", ins_out_valid); end
        n_compared++; if (fetch_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL cold_busy_end got=%0h want=0", fetch_busy); end
    endtask

    task automatic test_hit();
        issue_fetch(32'h0000_010C);
        n_compared++; if (ins_out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hit_valid got=%0h want=1", ins_out_valid); end
        n_compared++; if (ins_out !== 32'hC0DE_010C) begin n_mismatched++; $display("[TB] FAIL hit_data got=%0h want=c0de010c", ins_out); end
        n_compared++; if (ic_flag !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hit_ic_flag got=%0h want=0", ic_flag); end
        flush = 1'b1;
        issue_fetch(32'h0000_0100);
        flush = 1'b0;
        n_compared++; if (ins_out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hit_flush_valid got=%0h want=0", ins_out_valid); end
        n_compared++; if (fetch_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hit_flush_busy got=%0h want=0", fetch_busy); end
    endtask

    task automatic test_conflict();
        logic [31:0] a;
        issue_fetch(32'h0000_0500);
        n_compared++; if (ic_flag !== 1'b1) begin n_mismatched++; $display("[TB] FAIL evict_ic_flag got=%0h want=1", ic_flag); end
        for (int k = 0; k < 4; k++) begin
            serve_word(0, a);
            n_compared++; if (a !== 32'h500 + 32'(k * 4)) begin n_mismatched++; $display("[TB] FAIL evict_addr%0d got=%0h want=%0h", k, a, 32'h500 + 32'(k * 4)); end
        end
        n_compared++; if (ins_out !== 32'hC0DE_0500 || ins_out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL evict_resp got=%0h/%0h want=c0de0500/1", ins_out, ins_out_valid); end
        tick();
        issue_fetch(32'h0000_0100);
        n_compared++; if (ic_flag !== 1'b1) begin n_mismatched++; $display("[TB] FAIL evict_remiss got=%0h want=1", ic_flag); end
        for (int k = 0; k < 4; k++) serve_word(0, a);
        n_compared++; if (ins_out !== 32'hC0DE_0100 || ins_out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL evict_refill_resp got=%0h/%0h want=c0de0100/1", ins_out, ins_out_valid); end
        tick();
    endtask

    task automatic test_flush_refill();
        logic [31:0] a;
        issue_fetch(32'h0000_0218);
        serve_word(0, a);
        serve_word(0, a);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_compared++; if (ic_flag !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_still_refill got=%0h want=1", ic_flag); end
        for (int k = 2; k < 4; k++) begin
            serve_word(0, a);
            n_compared++; if (a !== 32'h210 + 32'(k * 4)) begin n_mismatched++; $display("[TB] FAIL flush_addr%0d got=%0h want=%0h", k, a, 32'h210 + 32'(k * 4)); end
        end
        n_compared++; if (ins_out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_resp_suppressed got=%0h want=0", ins_out_valid); end
        tick();
        issue_fetch(32'h0000_0218);
        n_compared++; if (ins_out_valid !== 1'b1 || ins_out !== 32'hC0DE_0218) begin n_mismatched++; $display("[TB] FAIL flush_then_hit got=%0h/%0h want=c0de0218/1", ins_out, ins_out_valid); end
        n_compared++; if (ic_flag !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_then_hit_flag got=%0h want=0", ic_flag); end
    endtask

    task automatic test_rdy_low();
        logic [31:0] a;
        issue_fetch(32'h0000_0324);
        serve_word(0, a);
        rdy     = 1'b0;
        ins     = 32'hDEAD_BEEF;
        ins_rdy = 1'b1;
        tick();
        ins_rdy = 1'b0;
        tick();
        tick();
        n_compared++; if (ins_addr !== 32'h324) begin n_mismatched++; $display("[TB] FAIL rdy_hold_addr got=%0h want=324", ins_addr); end
        n_compared++; if (ic_flag !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rdy_hold_flag got=%0h want=1", ic_flag); end
        rdy = 1'b1;
        for (int k = 1; k < 4; k++) begin
            serve_word(0, a);
            n_compared++; if (a !== 32'h320 + 32'(k * 4)) begin n_mismatched++; $display("[TB] FAIL rdy_resume_addr%0d got=%0h want=%0h", k, a, 32'h320 + 32'(k * 4)); end
        end
        n_compared++; if (ins_out !== 32'hC0DE_0324 || ins_out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rdy_resp got=%0h/%0h want=c0de0324/1", ins_out, ins_out_valid); end
        tick();
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] a;
        issue_fetch(32'h0000_0418);
        serve_word(0, a);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_compared++; if (ic_flag !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rstmid_ic_flag got=%0h want=0", ic_flag); end
        n_compared++; if (fetch_busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rstmid_busy got=%0h want=0", fetch_busy); end
        n_compared++; if (ins_addr !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rstmid_addr got=%0h want=0", ins_addr); end
        n_compared++; if (ins_out !== 32'h0 || ins_out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rstmid_out got=%0h/%0h want=0/0", ins_out, ins_out_valid); end
        issue_fetch(32'h0000_0324);
        n_compared++; if (ic_flag !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rstmid_remiss got=%0h want=1", ic_flag); end
        for (int k = 0; k < 4; k++) serve_word(0, a);
        n_compared++; if (ins_out !== 32'hC0DE_0324 || ins_out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rstmid_refill_resp got=%0h/%0h want=c0de0324/1", ins_out, ins_out_valid); end
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_refill();
        test_rdy_low();
        test_reset_mid_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
